// File: rtl/rand_synth_pkg.sv
// Shared types and helpers for the randomized-stall stream sink:
// the FSM state encoding and the 16-bit Galois LFSR step function.
package rand_synth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } stall_state_e;

  localparam int unsigned    LfsrWidth = 16;
  localparam logic [15:0]    LfsrTaps  = 16'hB400;
  localparam int unsigned    CntWidth  = 16;

  // One step of a right-shifting Galois LFSR: shift out bit 0 and, when it
  // was set, fold the tap mask into the shifted value.
  function automatic logic [LfsrWidth-1:0] lfsr_next(input logic [LfsrWidth-1:0] s);
    return (s >> 1) ^ (s[0] ? LfsrTaps : '0);
  endfunction

endpackage

// File: rtl/lfsr_16.sv
// Free-running 16-bit Galois LFSR. A zero seed would lock the register at
// zero forever, so it is replaced by 16'h0001.
module lfsr_16
  import rand_synth_pkg::*;
#(
  parameter logic [LfsrWidth-1:0] Seed = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  output logic [LfsrWidth-1:0] state_o
);

  localparam logic [LfsrWidth-1:0] SeedEff = (Seed == '0) ? 16'h0001 : Seed;

  logic [LfsrWidth-1:0] state_q;

  // Advance the sequence every enabled cycle; reset re-seeds it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst_ni) begin
      state_q <= SeedEff;
    end else if (en_i) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/rand_stall_sink.sv
// Valid/ready stream sink that stalls each beat for a pseudo-random number of
// cycles in [MinWait, MaxWait] before raising ready, and pulses proto_err_o
// when the source drops valid or changes data while the beat is stalled.
module rand_stall_sink
  import rand_synth_pkg::*;
#(
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          MinWait   = 0,
  parameter int unsigned          MaxWait   = 8,
  parameter logic [LfsrWidth-1:0] LfsrSeed  = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 valid_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 ready_o,
  output logic                 ack_o,
  output logic [DataWidth-1:0] data_o,
  output logic [31:0]          xfer_cnt_o,
  output logic                 proto_err_o
);

  // The stall counter is 16 bits wide, so the wait range must fit in it.
  if (MinWait > MaxWait || MaxWait >= 32'd65536) begin : g_bad_wait_range
    $error("rand_stall_sink: need MinWait <= MaxWait < 65536");
  end

  localparam int unsigned Span = MaxWait - MinWait + 1;

  stall_state_e         state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic [DataWidth-1:0] ref_q, ref_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [31:0]          xfer_q, xfer_d;
  logic                 ack_q, ack_d;
  logic                 perr_q, perr_d;

  logic [LfsrWidth-1:0] lfsr;
  logic [CntWidth-1:0]  draw;

  lfsr_16 #(
    .Seed (LfsrSeed)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (1'b1),
    .state_o (lfsr)
  );

  // Stall length for a beat arriving now; folds to a constant when Span is 1.
  assign draw = CntWidth'(MinWait + (32'(lfsr) % Span));

  // Next-state and datapath decode for the IDLE -> WAIT -> READY beat cycle.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    data_d  = data_q;
    xfer_d  = xfer_q;
    ack_d   = 1'b0;
    perr_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (valid_i && en_i) begin
          ref_d   = data_i;
          cnt_d   = draw;
          state_d = (draw == '0) ? ST_READY : ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (!valid_i) begin
          // Source withdrew the beat: flag it and forget the beat.
          perr_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          if (data_i != ref_q) begin
            // Re-arm the reference so a single change reports only once.
            perr_d = 1'b1;
            ref_d  = data_i;
          end
          if (cnt_q == CntWidth'(1)) begin
            cnt_d   = '0;
            state_d = ST_READY;
          end else begin
            cnt_d = cnt_q - CntWidth'(1);
          end
        end
      end

      ST_READY: begin
        if (!valid_i) begin
          perr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          // ready is high here, so valid completes the handshake this edge.
          perr_d  = (data_i != ref_q);
          data_d  = data_i;
          xfer_d  = xfer_q + 32'd1;
          ack_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    ready_d = (state_d == ST_READY);
  end

  // FSM state, stall counter and the registered ready flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Payload registers, beat counter and the one-cycle status pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ref_q  <= '0;
      data_q <= '0;
      xfer_q <= '0;
      ack_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      ref_q  <= ref_d;
      data_q <= data_d;
      xfer_q <= xfer_d;
      ack_q  <= ack_d;
      perr_q <= perr_d;
    end
  end

  assign ready_o     = ready_q;
  assign ack_o       = ack_q;
  assign data_o      = data_q;
  assign xfer_cnt_o  = xfer_q;
  assign proto_err_o = perr_q;

endmodule

// File: tb/tb_rand_stall_sink.sv
// Scoreboard bench for rand_stall_sink: three instances (constant wait 3,
// zero wait, random [2,5]) share clock and reset. Stimulus pushes the expected
// {data, count} of each beat; a negedge monitor pops on every ack.
module tb_rand_stall_sink;
  import rand_synth_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  en;
  logic [2:0]  valid;
  logic [31:0] din   [3];
  logic        ready [3];
  logic        ack   [3];
  logic        perr  [3];
  logic [31:0] dout  [3];
  logic [31:0] xcnt  [3];

  exp_t        q0[$], q1[$], q2[$];
  logic [31:0] exp_cnt  [3];
  int          perr_cnt [3];
  int          tests = 0;
  int          fails = 0;
  int          seq_a [5];
  int          seq_b [5];

  always #5 clk = ~clk;

  rand_stall_sink #(.DataWidth(32), .MinWait(3), .MaxWait(3)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en[0]), .valid_i(valid[0]), .data_i(din[0]),
    .ready_o(ready[0]), .ack_o(ack[0]), .data_o(dout[0]), .xfer_cnt_o(xcnt[0]),
    .proto_err_o(perr[0]));

  rand_stall_sink #(.DataWidth(32), .MinWait(0), .MaxWait(0)) u_z (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en[1]), .valid_i(valid[1]), .data_i(din[1]),
    .ready_o(ready[1]), .ack_o(ack[1]), .data_o(dout[1]), .xfer_cnt_o(xcnt[1]),
    .proto_err_o(perr[1]));

  rand_stall_sink #(.DataWidth(32), .MinWait(2), .MaxWait(5)) u_r (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en[2]), .valid_i(valid[2]), .data_i(din[2]),
    .ready_o(ready[2]), .ack_o(ack[2]), .data_o(dout[2]), .xfer_cnt_o(xcnt[2]),
    .proto_err_o(perr[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input logic [31:0] v);
    exp_t e;
    exp_cnt[d] = exp_cnt[d] + 32'd1;
    e.data = v;
    e.cnt  = exp_cnt[d];
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic sb_check(input int d);
    exp_t e;
    int   sz;
    sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      check($sformatf("sb_unexpected_ack_%0d", d), 32'd1, 32'd0);
    end else begin
      case (d)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("sb_data_%0d", d), dout[d], e.data);
      check($sformatf("sb_cnt_%0d", d), xcnt[d], e.cnt);
    end
  endtask

  // Monitor: compare every acknowledged beat and count error pulses.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (perr[d] === 1'b1) perr_cnt[d]++;
      if (ack[d] === 1'b1) sb_check(d);
    end
  end

  task automatic raise(input int d, input logic [31:0] v);
    @(posedge clk);
    #1;
    valid[d] = 1'b1;
    din[d]   = v;
  endtask

  // Counts negedges with ready low, ending at the first negedge with ready high.
  task automatic wait_ready(input int d, output int gap);
    gap = 0;
    @(negedge clk);
    while (ready[d] !== 1'b1 && gap < 200) begin
      gap++;
      @(negedge clk);
    end
    if (ready[d] !== 1'b1) check($sformatf("ready_timeout_%0d", d), 32'(ready[d]), 32'd1);
  endtask

  task automatic handshake(input int d);
    @(posedge clk);
    #1;
    valid[d] = 1'b0;
  endtask

  // One full beat; stall is the draw N (ready seen N+1 negedges after raise).
  task automatic send_beat(input int d, input logic [31:0] v, output int stall);
    int gap;
    raise(d, v);
    push_exp(d, v);
    wait_ready(d, gap);
    handshake(d);
    stall = gap - 1;
  endtask

  task automatic run_seq(input bit second);
    int st;
    for (int k = 0; k < 5; k++) begin
      send_beat(2, 32'h100 + 32'(k), st);
      if (second) seq_b[k] = st;
      else        seq_a[k] = st;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_ready_%0d", tag, d), 32'(ready[d]), 32'd0);
      check($sformatf("%s_ack_%0d", tag, d), 32'(ack[d]), 32'd0);
      check($sformatf("%s_perr_%0d", tag, d), 32'(perr[d]), 32'd0);
      check($sformatf("%s_data_%0d", tag, d), dout[d], 32'd0);
      check($sformatf("%s_cnt_%0d", tag, d), xcnt[d], 32'd0);
    end
    check({tag, "_state"}, 32'(u_r.state_q), 32'(ST_IDLE));
    check({tag, "_lfsr_seed"}, 32'(u_r.u_lfsr.state_q), 32'h0000_ACE1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st, gap, p0;
    logic [3:0]  seen;
    logic        flag;

    en    = '1;
    valid = '0;
    for (int d = 0; d < 3; d++) begin
      din[d]      = '0;
      exp_cnt[d]  = '0;
      perr_cnt[d] = 0;
    end

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_seq(1'b0);

    // Constant wait of 3: ready four negedges after the draw edge, ack next.
    send_beat(0, 32'h55, st);
    check("const_stall", 32'(st), 32'd3);
    @(negedge clk);
    check("const_ack", 32'(ack[0]), 32'd1);
    check("const_data", dout[0], 32'h55);
    check("const_cnt", xcnt[0], 32'd1);

    // Zero wait streaming: valid held high, one accept every two cycles.
    @(posedge clk);
    #1;
    valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din[1] = 32'(i);
      push_exp(1, 32'(i));
      wait_ready(1, gap);
      check($sformatf("zero_wait_gap_%0d", i), 32'(gap), 32'd1);
      @(posedge clk);
      #1;
    end
    valid[1] = 1'b0;
    @(negedge clk);
    check("zero_wait_data", dout[1], 32'd9);
    check("zero_wait_cnt", xcnt[1], 32'd10);

    // Random range [2,5]: every draw in range, all four values observed.
    seen = '0;
    for (int i = 0; i < 1000; i++) begin
      send_beat(2, 32'(i * 3 + 7), st);
      if (st < 2 || st > 5) check($sformatf("rand_stall_range_%0d", i), 32'(st), 32'd2);
      else seen[st-2] = 1'b1;
    end
    @(negedge clk);
    check("rand_all_values_seen", 32'(seen), 32'hF);
    check("rand_no_proto_err", 32'(perr_cnt[2]), 32'd0);

    // Valid dropped in WAIT: one error pulse, beat abandoned.
    p0 = perr_cnt[2];
    raise(2, 32'hB0);
    @(posedge clk);
    #1;
    valid[2] = 1'b0;
    repeat (3) @(negedge clk);
    check("drop_perr_pulses", 32'(perr_cnt[2] - p0), 32'd1);
    check("drop_state_idle", 32'(u_r.state_q), 32'(ST_IDLE));
    check("drop_cnt_unchanged", xcnt[2], exp_cnt[2]);
    check("drop_ready_low", 32'(ready[2]), 32'd0);

    // Data changed while stalled: one pulse, beat still accepted.
    p0 = perr_cnt[2];
    raise(2, 32'hA0);
    push_exp(2, 32'hA1);
    @(posedge clk);
    #1;
    din[2] = 32'hA1;
    wait_ready(2, gap);
    handshake(2);
    @(negedge clk);
    check("chg_data_accepted", dout[2], 32'hA1);
    check("chg_perr_pulses", 32'(perr_cnt[2] - p0), 32'd1);

    // en low with valid high: ready never rises.
    en[2] = 1'b0;
    raise(2, 32'hE0);
    flag = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready[2] !== 1'b0) flag = 1'b1;
    end
    check("en_low_ready_stays_0", 32'(flag), 32'd0);
    check("en_low_state_idle", 32'(u_r.state_q), 32'(ST_IDLE));
    valid[2] = 1'b0;
    en[2]    = 1'b1;

    // en dropped after the draw does not abort the beat.
    raise(2, 32'hC0);
    push_exp(2, 32'hC0);
    @(posedge clk);
    #1;
    en[2] = 1'b0;
    wait_ready(2, gap);
    handshake(2);
    en[2] = 1'b1;
    @(negedge clk);
    check("en_mid_beat_data", dout[2], 32'hC0);

    // Counter wrap: deposit all-ones, one beat brings it to zero silently.
    @(negedge clk);
    #1;
    u_c.xfer_q = 32'hFFFF_FFFF;
    exp_cnt[0] = 32'hFFFF_FFFF;
    p0 = perr_cnt[0];
    send_beat(0, 32'h77, st);
    @(negedge clk);
    check("wrap_cnt_zero", xcnt[0], 32'd0);
    check("wrap_no_perr", 32'(perr_cnt[0] - p0), 32'd0);

    // Reset while READY: ready drops at once, LFSR re-seeded, draws repeat.
    raise(2, 32'hD0);
    wait_ready(2, gap);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    valid = '0;
    q0.delete();
    q1.delete();
    q2.delete();
    for (int d = 0; d < 3; d++) exp_cnt[d] = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_seq(1'b1);
    for (int k = 0; k < 5; k++)
      check($sformatf("reseed_draw_%0d", k), 32'(seq_b[k]), 32'(seq_a[k]));

    repeat (3) @(negedge clk);
    check("sb_q0_drained", 32'(q0.size()), 32'd0);
    check("sb_q1_drained", 32'(q1.size()), 32'd0);
    check("sb_q2_drained", 32'(q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
